// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch stage for the RV32IC out-of-order core. Owns the
// architectural fetch PC. It issues halfword-aligned 32-bit fetch requests to
// the instruction cache and holds each returned instruction. It shows the held
// instruction to the decoder and PC predictor. When the instruction queue can
// take it, the unit pushes the instruction, its PC and its predicted next PC.
// A JALR stalls in HOLD until its base operand is available. A ROB flush
// redirects the PC and drops any in-flight or held instruction.
//
// Handshakes:
//   ic_req_out / ic_valid_in : ic_req_out stays high from REQ through WAIT.
//     The cache answers with a single-cycle ic_valid_in pulse.
//   iq_push_out / iq_full_in : iq_push_out is a one-cycle strobe. It is only
//     raised when iq_full_in is low. The queue captures iq_* on the rising
//     edge that ends that cycle.
//
// Ports:
//   clk_in, rst_n_in         clock, async active-low reset
//   rdy_in                   global ready; low freezes every register
//   ic_req_out, ic_addr_out  fetch request and address (bit 0 always 0)
//   ic_valid_in, ic_data_in  cache response pulse and 32-bit data
//   cur_pc_out, cur_inst_out held instruction and PC, to decoder/predictor
//   is_jalr_in, is_ctrl_in   decoder classification of held instruction
//   pred_pc_in               predictor next PC for held instruction
//   val1_valid_in            JALR base operand available
//   iq_full_in               instruction queue cannot accept
//   iq_push_out, iq_inst_out, iq_pc_out, iq_pred_pc_out, iq_is_c_out
//                            instruction queue write port
//   flush_in, flush_pc_in    ROB redirect and its target
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    output logic        ic_req_out,
    output logic [31:0] ic_addr_out,
    input  logic        ic_valid_in,
    input  logic [31:0] ic_data_in,
    output logic [31:0] cur_pc_out,
    output logic [31:0] cur_inst_out,
    input  logic        is_jalr_in,
    input  logic        is_ctrl_in,
    input  logic [31:0] pred_pc_in,
    input  logic        val1_valid_in,
    input  logic        iq_full_in,
    output logic        iq_push_out,
    output logic [31:0] iq_inst_out,
    output logic [31:0] iq_pc_out,
    output logic [31:0] iq_pred_pc_out,
    output logic        iq_is_c_out,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        is_c_q;

    logic        push;
    logic [31:0] next_pc;

    // A push needs queue space and, for JALR, a known base register value.
    // A flush or a frozen pipeline suppresses the push.
    assign push = (state_q == S_HOLD) && rdy_in && !flush_in && !iq_full_in &&
                  (!is_jalr_in || val1_valid_in);

    assign next_pc = is_ctrl_in ? pred_pc_in
                                : (pc_q + (is_c_q ? 32'd2 : 32'd4));

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_REQ;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush_in) begin
            // A request still in flight must be drained so that its stale
            // response is not taken as the redirect target's instruction.
            if ((state_q == S_WAIT || state_q == S_DRAIN) && !ic_valid_in) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ:   state_d = S_WAIT;
                S_WAIT:  state_d = ic_valid_in ? S_HOLD : S_WAIT;
                S_HOLD:  state_d = push ? S_REQ : S_HOLD;
                S_DRAIN: state_d = ic_valid_in ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end
    end

    // PC and instruction latches
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pc_q   <= RESET_PC;
            inst_q <= 32'h0;
            is_c_q <= 1'b0;
        end else if (rdy_in) begin
            if (flush_in) begin
                pc_q   <= flush_pc_in;
                inst_q <= 32'h0;
                is_c_q <= 1'b0;
            end else if (state_q == S_WAIT && ic_valid_in) begin
                // Low bits other than 2'b11 mark a 16-bit instruction. Only
                // the low halfword belongs to it.
                if (ic_data_in[1:0] != 2'b11) begin
                    inst_q <= {16'h0, ic_data_in[15:0]};
                    is_c_q <= 1'b1;
                end else begin
                    inst_q <= ic_data_in;
                    is_c_q <= 1'b0;
                end
            end else if (push) begin
                pc_q <= next_pc;
            end
        end
    end

    // Output decode
    always_comb begin
        ic_req_out     = (state_q == S_REQ) || (state_q == S_WAIT);
        ic_addr_out    = {pc_q[31:1], 1'b0};
        cur_pc_out     = pc_q;
        cur_inst_out   = inst_q;
        iq_push_out    = push;
        iq_inst_out    = inst_q;
        iq_pc_out      = pc_q;
        iq_pred_pc_out = next_pc;
        iq_is_c_out    = is_c_q;
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        ic_req_out;
    logic [31:0] ic_addr_out;
    logic        ic_valid_in;
    logic [31:0] ic_data_in;
    logic [31:0] cur_pc_out;
    logic [31:0] cur_inst_out;
    logic        is_jalr_in;
    logic        is_ctrl_in;
    logic [31:0] pred_pc_in;
    logic        val1_valid_in;
    logic        iq_full_in;
    logic        iq_push_out;
    logic [31:0] iq_inst_out;
    logic [31:0] iq_pc_out;
    logic [31:0] iq_pred_pc_out;
    logic        iq_is_c_out;
    logic        flush_in;
    logic [31:0] flush_pc_in;

    int tests_run = 0;
    int tests_failed = 0;

    inst_fetch_unit dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .ic_req_out     (ic_req_out),
        .ic_addr_out    (ic_addr_out),
        .ic_valid_in    (ic_valid_in),
        .ic_data_in     (ic_data_in),
        .cur_pc_out     (cur_pc_out),
        .cur_inst_out   (cur_inst_out),
        .is_jalr_in     (is_jalr_in),
        .is_ctrl_in     (is_ctrl_in),
        .pred_pc_in     (pred_pc_in),
        .val1_valid_in  (val1_valid_in),
        .iq_full_in     (iq_full_in),
        .iq_push_out    (iq_push_out),
        .iq_inst_out    (iq_inst_out),
        .iq_pc_out      (iq_pc_out),
        .iq_pred_pc_out (iq_pred_pc_out),
        .iq_is_c_out    (iq_is_c_out),
        .flush_in       (flush_in),
        .flush_pc_in    (flush_pc_in)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    // Advance one cycle; inputs change 1ns after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Compare at the falling edge of the current cycle.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Request cycle at exp_addr, one WAIT cycle with the response, then
    // return in the HOLD cycle.
    task automatic fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
        @(negedge clk_in);
        chk({tag, "_req"}, {31'h0, ic_req_out}, 32'h1);
        chk({tag, "_addr"}, ic_addr_out, exp_addr);
        tick();
        ic_valid_in = 1'b1;
        ic_data_in  = data;
        @(negedge clk_in);
        chk({tag, "_wait_nopush"}, {31'h0, iq_push_out}, 32'h0);
        tick();
        ic_valid_in = 1'b0;
        ic_data_in  = 32'h0;
    endtask

    task automatic chk_push(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic is_c, input logic [31:0] pred);
        @(negedge clk_in);
        chk({tag, "_push"}, {31'h0, iq_push_out}, 32'h1);
        chk({tag, "_pc"}, iq_pc_out, pc);
        chk({tag, "_inst"}, iq_inst_out, inst);
        chk({tag, "_is_c"}, {31'h0, iq_is_c_out}, {31'h0, is_c});
        chk({tag, "_pred"}, iq_pred_pc_out, pred);
    endtask

    initial begin
        rst_n_in      = 1'b0;
        rdy_in        = 1'b1;
        ic_valid_in   = 1'b0;
        ic_data_in    = 32'h0;
        is_jalr_in    = 1'b0;
        is_ctrl_in    = 1'b0;
        pred_pc_in    = 32'h0;
        val1_valid_in = 1'b0;
        iq_full_in    = 1'b0;
        flush_in      = 1'b0;
        flush_pc_in   = 32'h0;

        // Reset state
        tick();
        tick();
        @(negedge clk_in);
        chk("rst_addr", ic_addr_out, 32'h0);
        chk("rst_push", {31'h0, iq_push_out}, 32'h0);
        chk("rst_cur_pc", cur_pc_out, 32'h0);
        chk("rst_cur_inst", cur_inst_out, 32'h0);
        tick();
        rst_n_in = 1'b1;

        // 32-bit instruction at 0
        fetch("f0", 32'h0, 32'h0000_0093);
        chk_push("f0", 32'h0, 32'h0000_0093, 1'b0, 32'h4);
        tick();

        // Compressed instruction at 4, upper half must be dropped
        fetch("c4", 32'h4, 32'hABCD_4501);
        chk_push("c4", 32'h4, 32'h0000_4501, 1'b1, 32'h6);
        chk("c4_cur_inst", cur_inst_out, 32'h0000_4501);
        tick();

        // Compressed nop at 6 brings the PC to 8
        fetch("c6", 32'h6, 32'h0000_0001);
        chk_push("c6", 32'h6, 32'h0000_0001, 1'b1, 32'h8);
        tick();

        // Branch at 8 predicted taken to 0x40
        fetch("br", 32'h8, 32'h0000_0063);
        is_ctrl_in = 1'b1;
        pred_pc_in = 32'h40;
        chk_push("br", 32'h8, 32'h0000_0063, 1'b0, 32'h40);
        tick();
        is_ctrl_in = 1'b0;
        pred_pc_in = 32'h0;

        // JALR at 0x40, base operand arrives on the 4th HOLD cycle
        fetch("jalr", 32'h40, 32'h0000_8067);
        is_jalr_in = 1'b1;
        is_ctrl_in = 1'b1;
        pred_pc_in = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("jalr_stall_nopush", {31'h0, iq_push_out}, 32'h0);
            chk("jalr_stall_pc", cur_pc_out, 32'h40);
            tick();
        end
        val1_valid_in = 1'b1;
        chk_push("jalr", 32'h40, 32'h0000_8067, 1'b0, 32'h100);
        tick();
        is_jalr_in    = 1'b0;
        is_ctrl_in    = 1'b0;
        val1_valid_in = 1'b0;
        pred_pc_in    = 32'h0;

        // Flush to 0x200 while waiting at 0x100; stale response 2 cycles later
        @(negedge clk_in);
        chk("fl_req_addr", ic_addr_out, 32'h100);
        tick();
        flush_in    = 1'b1;
        flush_pc_in = 32'h200;
        @(negedge clk_in);
        chk("fl_wait_nopush", {31'h0, iq_push_out}, 32'h0);
        tick();
        flush_in    = 1'b0;
        flush_pc_in = 32'h0;
        @(negedge clk_in);
        chk("fl_drain_pc", cur_pc_out, 32'h200);
        chk("fl_drain_nopush", {31'h0, iq_push_out}, 32'h0);
        tick();
        ic_valid_in = 1'b1;
        ic_data_in  = 32'h0000_0093;
        @(negedge clk_in);
        chk("fl_stale_nopush", {31'h0, iq_push_out}, 32'h0);
        tick();
        ic_valid_in = 1'b0;
        ic_data_in  = 32'h0;
        @(negedge clk_in);
        chk("fl_cur_inst_dropped", cur_inst_out, 32'h0);

        // Fetch at 0x200, queue full 5 cycles with a frozen cycle in the middle
        fetch("full", 32'h200, 32'h0000_0013);
        iq_full_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                rdy_in      = 1'b0;
                flush_in    = 1'b1;
                flush_pc_in = 32'h300;
            end else begin
                rdy_in      = 1'b1;
                flush_in    = 1'b0;
                flush_pc_in = 32'h0;
            end
            @(negedge clk_in);
            chk("full_nopush", {31'h0, iq_push_out}, 32'h0);
            chk("full_pc", cur_pc_out, 32'h200);
            tick();
        end
        rdy_in      = 1'b1;
        flush_in    = 1'b0;
        flush_pc_in = 32'h0;
        iq_full_in  = 1'b0;
        chk_push("full", 32'h200, 32'h0000_0013, 1'b0, 32'h204);
        tick();
        @(negedge clk_in);
        chk("full_single_push", {31'h0, iq_push_out}, 32'h0);
        chk("full_next_addr", ic_addr_out, 32'h204);

        // Redirect from REQ to the top halfword; PC wraps to 0
        flush_in    = 1'b1;
        flush_pc_in = 32'hFFFF_FFFE;
        tick();
        flush_in    = 1'b0;
        flush_pc_in = 32'h0;
        fetch("wrap", 32'hFFFF_FFFE, 32'h0000_0001);
        chk_push("wrap", 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 32'h0);
        tick();
        @(negedge clk_in);
        chk("wrap_next_addr", ic_addr_out, 32'h0);
        chk("wrap_req", {31'h0, ic_req_out}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
